// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory access controller: data width,
// controller state encoding, default timeout and address alignment helper.
package mem_if_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // Memory is word addressed; byte offset bits are dropped, never faulted.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive cycles with run high; expired flags the cycle in which
// the running count (starting at 1) reaches TIMEOUT_CYCLES.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_watchdog
    import mem_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    // cnt holds the number of run cycles already completed
    logic [CW-1:0] cnt;

    // Count while run is high, clear as soon as it drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Current cycle number is cnt+1, so compare against TIMEOUT_CYCLES-1
    always_comb begin
        expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller between the multi-cycle control FSM and a
// handshaked memory. A request in IDLE latches address/data, ACCESS holds
// the access until mem_ready, DONE pulses for one cycle.
// Optional feature: define MEM_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES cycles with an Err pulse.
module mem_access_ctrl
    import mem_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [XLEN-1:0] Adr,
    input  logic [XLEN-1:0] WriteData,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] ReadData,
    output logic            Stall,
    output logic            Done,
    output logic            Err
);

    mem_state_t state, state_next;
    logic       req;
    logic       expired;
    logic       unused_adr;

    assign req        = MemRead | MemWrite;
    assign unused_adr = ^Adr[1:0];

`ifdef MEM_TIMEOUT_EN
    logic err_q;

    mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .run    (state == ACCESS),
        .expired(expired)
    );

    // Remember whether ACCESS ended by timeout; only observable in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == ACCESS) && !mem_ready && expired;
        end
    end

    assign Err = err_q;
`else
    logic [31:0] unused_cfg;

    assign unused_cfg = 32'(TIMEOUT_CYCLES);
    assign expired    = 1'b0;
    assign Err        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; mem_ready wins over a simultaneous timeout
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req) state_next = ACCESS;
            ACCESS:  if (mem_ready || expired) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs; Stall is gated by reset so it drops immediately
    // even while the control FSM still presents a request
    always_comb begin
        mem_valid = (state == ACCESS);
        Done      = (state == DONE);
        Stall     = !reset && (((state == IDLE) && req) || (state == ACCESS));
    end

    // Request latch and read-data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            ReadData  <= '0;
        end else begin
            if ((state == IDLE) && req) begin
                mem_addr  <= align_word(Adr);
                mem_wdata <= WriteData;
                mem_we    <= MemWrite;
            end
            if ((state == ACCESS) && mem_ready && !mem_we) begin
                ReadData <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl plus hand-written
// sequences for reset mid-access, back-to-back requests and timeout.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] Adr, WriteData;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata, ReadData;
    logic        Stall, Done, Err;

    int tests  = 0;
    int failed = 0;

    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Adr      (Adr),
        .WriteData(WriteData),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .ReadData (ReadData),
        .Stall    (Stall),
        .Done     (Done),
        .Err      (Err)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wdata;
        int          delay;     // ACCESS cycles without mem_ready before it rises
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_rdata; // ReadData expected after DONE
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0000_0000, 0, 32'h0051_0093,
                    32'h0000_0104, 1'b0, 32'h0051_0093};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_2003, 32'hCAFE_F00D, 4, 32'hDEAD_BEEF,
                    32'h0000_2000, 1'b1, 32'h0051_0093};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_3006, 32'h1234_5678, 1, 32'hFFFF_FFFF,
                    32'h0000_3004, 1'b1, 32'h0051_0093};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 2, 32'hA5A5_5A5A,
                    32'hFFFF_FFFC, 1'b0, 32'hA5A5_5A5A};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 0, 32'h0000_0000,
                    32'h0000_0008, 1'b0, 32'h0000_0000};

        reset = 1'b1;
        idle_inputs();
        Adr       = '0;
        WriteData = '0;
        mem_rdata = '0;
        #2;
        chk("rst_valid", 32'(mem_valid), 0);
        chk("rst_stall", 32'(Stall), 0);
        chk("rst_done",  32'(Done), 0);
        chk("rst_err",   32'(Err), 0);
        chk("rst_addr",  mem_addr, 0);
        chk("rst_rdata", ReadData, 0);
        step();
        reset = 1'b0;
        exp_rd = '0;

        // mem_ready outside ACCESS is ignored
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_7777;
        step();
        chk("idle_ready_valid", 32'(mem_valid), 0);
        chk("idle_ready_rdata", ReadData, 0);
        chk("idle_ready_done",  32'(Done), 0);
        mem_ready = 1'b0;

        foreach (vecs[i]) begin
            // request cycle
            MemRead   = vecs[i].rd;
            MemWrite  = vecs[i].wr;
            Adr       = vecs[i].adr;
            WriteData = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d_req_stall", i), 32'(Stall), 1);
            chk($sformatf("v%0d_req_valid", i), 32'(mem_valid), 0);
            step();
            // scramble the datapath inputs: latched values must hold
            Adr       = ~vecs[i].adr;
            WriteData = ~vecs[i].wdata;
            for (int w = 0; w <= vecs[i].delay; w++) begin
                mem_ready = (w == vecs[i].delay);
                mem_rdata = vecs[i].rdata;
                #1;
                chk($sformatf("v%0d_acc%0d_valid", i, w), 32'(mem_valid), 1);
                chk($sformatf("v%0d_acc%0d_stall", i, w), 32'(Stall), 1);
                chk($sformatf("v%0d_acc%0d_addr", i, w), mem_addr, vecs[i].exp_addr);
                chk($sformatf("v%0d_acc%0d_we", i, w), 32'(mem_we), 32'(vecs[i].exp_we));
                if (vecs[i].exp_we)
                    chk($sformatf("v%0d_acc%0d_wdata", i, w), mem_wdata, vecs[i].wdata);
                step();
            end
            mem_ready = 1'b0;
            chk($sformatf("v%0d_done", i), 32'(Done), 1);
            chk($sformatf("v%0d_done_stall", i), 32'(Stall), 0);
            chk($sformatf("v%0d_done_valid", i), 32'(mem_valid), 0);
            chk($sformatf("v%0d_done_err", i), 32'(Err), 0);
            chk($sformatf("v%0d_readdata", i), ReadData, vecs[i].exp_rdata);
            idle_inputs();
            step();
            chk($sformatf("v%0d_idle_done", i), 32'(Done), 0);
            exp_rd = vecs[i].exp_rdata;
        end

        // reset asserted in the third ACCESS cycle, request kept high
        MemRead = 1'b1;
        Adr     = 32'h0000_0444;
        step();
        step();
        step();
        chk("mid_acc_valid", 32'(mem_valid), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(mem_valid), 0);
        chk("rst_mid_stall", 32'(Stall), 0);
        chk("rst_mid_rdata", ReadData, 0);
        chk("rst_mid_addr",  mem_addr, 0);
        step();
        chk("rst_hold_valid", 32'(mem_valid), 0);
        reset = 1'b0;
        exp_rd = '0;
        #1;
        // back in IDLE with request pending
        chk("post_rst_stall", 32'(Stall), 1);
        chk("post_rst_valid", 32'(mem_valid), 0);
        step();
        chk("post_rst_access", 32'(mem_valid), 1);
        chk("post_rst_addr", mem_addr, 32'h0000_0444);
        mem_ready = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        step();
        mem_ready = 1'b0;
        chk("post_rst_done", 32'(Done), 1);
        chk("post_rst_rdata", ReadData, 32'h1357_9BDF);
        exp_rd = 32'h1357_9BDF;

        // request still high through DONE: new access only from the IDLE after
        step();
        chk("hold_idle_done",  32'(Done), 0);
        chk("hold_idle_valid", 32'(mem_valid), 0);
        chk("hold_idle_stall", 32'(Stall), 1);
        step();
        chk("hold_second_valid", 32'(mem_valid), 1);
        mem_ready = 1'b1;
        mem_rdata = 32'h2468_ACE0;
        step();
        idle_inputs();
        chk("hold_second_done", 32'(Done), 1);
        chk("hold_second_rdata", ReadData, 32'h2468_ACE0);
        exp_rd = 32'h2468_ACE0;
        step();

`ifdef MEM_TIMEOUT_EN
        // no mem_ready: abort after 16 ACCESS cycles
        MemRead = 1'b1;
        step();
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("to_acc%0d_valid", c), 32'(mem_valid), 1);
            step();
        end
        chk("to_done", 32'(Done), 1);
        chk("to_err", 32'(Err), 1);
        chk("to_valid", 32'(mem_valid), 0);
        chk("to_rdata", ReadData, exp_rd);
        idle_inputs();
        step();
        chk("to_err_clear", 32'(Err), 0);
        // mem_ready on the 16th cycle completes normally
        MemRead = 1'b1;
        step();
        for (int c = 1; c <= 16; c++) begin
            mem_ready = (c == 16);
            mem_rdata = 32'h0BAD_F00D;
            step();
        end
        chk("to16_done", 32'(Done), 1);
        chk("to16_err", 32'(Err), 0);
        chk("to16_rdata", ReadData, 32'h0BAD_F00D);
        idle_inputs();
        step();
`else
        // without timeout the controller waits in ACCESS indefinitely
        MemRead = 1'b1;
        step();
        for (int c = 1; c <= 20; c++) step();
        chk("noto_valid", 32'(mem_valid), 1);
        chk("noto_err", 32'(Err), 0);
        chk("noto_done", 32'(Done), 0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        step();
        chk("noto_done_late", 32'(Done), 1);
        chk("noto_rdata", ReadData, 32'h0BAD_F00D);
        idle_inputs();
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
